response_monitor: RTL and testbench

RESPONSE_MONITOR -- requirements
Module: response_monitor

---
 rtl/response_monitor.sv | 119 +++++++++++
 tb/tb_response_monitor.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/response_monitor.sv
// Multi-channel packet accumulator: round-robin arbitration over input channels,
// per-channel running sums, and an optional two-word report (channel, sum) per packet.
module response_monitor #(
  parameter int WIDTH      = 16,
  parameter int CHANNELS   = 4,
  parameter int PACKET_LEN = 4,
  parameter int REPORT     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] input_in,
  input  logic [CHANNELS-1:0]       input_in_stb,
  output logic [CHANNELS-1:0]       input_in_ack,
  output logic [WIDTH-1:0]          output_out,
  output logic                      output_out_stb,
  input  logic                      output_out_ack
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {ARB, ACCEPT, REPORT_HDR, REPORT_SUM} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  grant, ptr, ptr_next, pick, sel;
  logic           found;
  int             idx;

  logic [WIDTH-1:0] sum   [CHANNELS];
  logic [15:0]      count [CHANNELS];

  logic [WIDTH-1:0] word, sum_new;
  logic [15:0]      count_new;
  logic             take, done;

  // Round-robin search starting at ptr (one past the last granted channel).
  always_comb begin
    found = 1'b0;
    pick  = grant;
    idx   = 0;
    sel   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = (int'(ptr) + i) % CHANNELS;
      sel = CW'(idx);
      if (!found && input_in_stb[sel]) begin
        found = 1'b1;
        pick  = sel;
      end
    end
  end

  assign word      = input_in[int'(grant)*WIDTH +: WIDTH];
  assign sum_new   = sum[grant] + word;
  assign count_new = count[grant] + 16'd1;
  assign done      = (count_new == 16'(PACKET_LEN));
  assign take      = (state == ACCEPT) && input_in_stb[grant];

  always_comb begin
    state_next     = state;
    ptr_next       = ptr;
    input_in_ack   = '0;
    output_out     = '0;
    output_out_stb = 1'b0;
    case (state)
      ARB: begin
        if (found) begin
          state_next = ACCEPT;
          ptr_next   = (int'(pick) == CHANNELS - 1) ? '0 : pick + 1'b1;
        end
      end
      ACCEPT: begin
        input_in_ack[grant] = 1'b1;
        if (take && done && (REPORT != 0)) state_next = REPORT_HDR;
        else                                state_next = ARB;
      end
      REPORT_HDR: begin
        output_out     = WIDTH'(grant);
        output_out_stb = 1'b1;
        if (output_out_ack) state_next = REPORT_SUM;
      end
      REPORT_SUM: begin
        output_out     = sum[grant];
        output_out_stb = 1'b1;
        if (output_out_ack) state_next = ARB;
      end
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB;
      grant <= '0;
      ptr   <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        sum[k]   <= '0;
        count[k] <= '0;
      end
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      if (state == ARB && found) grant <= pick;
      // Discard mode retires the packet on its last word since no report follows.
      if (take) begin
        if (done && (REPORT == 0)) begin
          sum[grant]   <= '0;
          count[grant] <= '0;
        end else begin
          sum[grant]   <= sum_new;
          count[grant] <= count_new;
        end
      end
      if (state == REPORT_SUM && output_out_ack) begin
        sum[grant]   <= '0;
        count[grant] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_response_monitor.sv
// Directed bench for response_monitor: queue-fed channel driver plus per-scenario checking tasks.
module tb_response_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] in_data;
  logic [3:0]  in_stb, in_ack;
  logic [15:0] out;
  logic        out_stb, out_ack;

  logic [63:0] d_data;
  logic [3:0]  d_stb, d_ack;
  logic [15:0] d_out;
  logic        d_out_stb, d_out_ack;

  response_monitor dut (
    .clk(clk), .rst(rst), .input_in(in_data), .input_in_stb(in_stb), .input_in_ack(in_ack),
    .output_out(out), .output_out_stb(out_stb), .output_out_ack(out_ack)
  );

  response_monitor #(.WIDTH(16), .CHANNELS(4), .PACKET_LEN(2), .REPORT(0)) dut_d (
    .clk(clk), .rst(rst), .input_in(d_data), .input_in_stb(d_stb), .input_in_ack(d_ack),
    .output_out(d_out), .output_out_stb(d_out_stb), .output_out_ack(d_out_ack)
  );

  int tests = 0;
  int fails = 0;
  int onehot_err = 0;

  logic [15:0] chan_q [4][$];
  int          in_q[$];
  int          in_outs[$];
  logic [15:0] out_q[$];

  // Records transfers at each edge, then presents the head of each channel queue.
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        if (in_ack[k] && in_stb[k]) begin
          in_q.push_back(k);
          in_outs.push_back(out_q.size());
          if (chan_q[k].size() > 0) void'(chan_q[k].pop_front());
        end
      end
      if (out_stb && out_ack) out_q.push_back(out);
      if ($countones(in_ack) > 1 || $countones(d_ack) > 1) onehot_err++;
    end
    #1;
    for (int k = 0; k < 4; k++) begin
      in_stb[k] = (chan_q[k].size() > 0);
      in_data[k*16 +: 16] = (chan_q[k].size() > 0) ? chan_q[k][0] : 16'h0000;
    end
  end

  task automatic apply_reset();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) chan_q[k].delete();
    in_q.delete();
    in_outs.delete();
    out_q.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic wait_outputs(input int n, input int budget, input string name);
    int c = 0;
    while (out_q.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    #2;
    tests++;
    if (out_q.size() < n) begin
      fails++;
      $display("FAIL %s_timeout: got %0d report words, required %0d", name, out_q.size(), n);
    end
  endtask

  task automatic check_out(input int i, input logic [15:0] exp, input string name);
    tests++;
    if (i >= out_q.size()) begin
      fails++;
      $display("FAIL %s[%0d]: missing, required %h", name, i, exp);
    end else if (out_q[i] !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %h, required %h", name, i, out_q[i], exp);
    end else
      $display("[TB] %s[%0d] report word %h ok", name, i, out_q[i]);
  endtask

  task automatic test_reset();
    int c = 0;
    apply_reset();
    out_ack = 1'b0;
    for (int i = 0; i < 4; i++) chan_q[0].push_back(16'h0003);
    while (out_stb !== 1'b1 && c < 100) begin
      @(posedge clk);
      #2;
      c++;
    end
    tests++;
    if (out_stb !== 1'b1) begin
      fails++;
      $display("FAIL reset_setup: out_stb %b, required 1", out_stb);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (out_stb !== 1'b0 || out !== 16'h0000 || in_ack !== 4'b0000) begin
      fails++;
      $display("FAIL reset_async: stb %b out %h ack %b, required 0 0000 0000", out_stb, out, in_ack);
    end else
      $display("[TB] reset_async outputs cleared ok");
    tests++;
    if (dut.sum[0] !== 16'h0000 || dut.count[0] !== 16'd0) begin
      fails++;
      $display("FAIL reset_state: sum %h count %0d, required 0000 0", dut.sum[0], dut.count[0]);
    end
    for (int k = 0; k < 4; k++) chan_q[k].delete();
    in_q.delete();
    in_outs.delete();
    out_q.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (in_ack !== 4'b0000 || out_stb !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: ack %b stb %b, required 0000 0", in_ack, out_stb);
    end
    repeat (10) @(posedge clk);
    #2;
    tests++;
    if (out_q.size() != 0) begin
      fails++;
      $display("FAIL reset_no_partial: got %0d report words, required 0", out_q.size());
    end
  endtask

  task automatic test_basic();
    apply_reset();
    out_ack = 1'b1;
    chan_q[2].push_back(16'h0001);
    chan_q[2].push_back(16'h0002);
    chan_q[2].push_back(16'h0003);
    chan_q[2].push_back(16'h0004);
    wait_outputs(2, 100, "basic");
    check_out(0, 16'h0002, "basic");
    check_out(1, 16'h000A, "basic");
    tests++;
    if (dut.sum[2] !== 16'h0000 || dut.count[2] !== 16'd0) begin
      fails++;
      $display("FAIL basic_clear: sum %h count %0d, required 0000 0", dut.sum[2], dut.count[2]);
    end
    tests++;
    if (in_q.size() != 4) begin
      fails++;
      $display("FAIL basic_xfers: got %0d input transfers, required 4", in_q.size());
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] exp [8];
    exp[0] = 16'h0000; exp[1] = 16'h4444; exp[2] = 16'h0001; exp[3] = 16'h8888;
    exp[4] = 16'h0002; exp[5] = 16'hCCCC; exp[6] = 16'h0003; exp[7] = 16'h1110;
    apply_reset();
    out_ack = 1'b1;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++) chan_q[k].push_back(16'(16'h1111 * (k + 1)));
    wait_outputs(8, 400, "rr");
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (i >= in_q.size() || in_q[i] != (i % 4)) begin
        fails++;
        $display("FAIL rr_grant[%0d]: got %0d, required %0d", i, (i < in_q.size()) ? in_q[i] : -1, i % 4);
      end
    end
    for (int i = 0; i < 8; i++) check_out(i, exp[i], "rr");
  endtask

  task automatic test_wrap();
    apply_reset();
    out_ack = 1'b1;
    chan_q[0].push_back(16'hFFFF);
    chan_q[0].push_back(16'hFFFF);
    chan_q[0].push_back(16'h0002);
    chan_q[0].push_back(16'h0001);
    wait_outputs(2, 100, "wrap");
    check_out(0, 16'h0000, "wrap");
    check_out(1, 16'h0001, "wrap");
  endtask

  task automatic test_backpressure();
    int c = 0;
    int n0;
    apply_reset();
    out_ack = 1'b0;
    for (int i = 0; i < 4; i++) chan_q[0].push_back(16'h0005);
    while (out_stb !== 1'b1 && c < 100) begin
      @(posedge clk);
      #2;
      c++;
    end
    n0 = in_q.size();
    chan_q[1].push_back(16'h0077);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #2;
      tests++;
      if (out_stb !== 1'b1 || out !== 16'h0000 || in_ack !== 4'b0000) begin
        fails++;
        $display("FAIL bp_hold[%0d]: stb %b out %h ack %b, required 1 0000 0000", i, out_stb, out, in_ack);
      end
    end
    out_ack = 1'b1;
    wait_outputs(2, 20, "bp");
    check_out(0, 16'h0000, "bp");
    check_out(1, 16'h0014, "bp");
    c = 0;
    while (in_q.size() <= n0 && c < 20) begin
      @(posedge clk);
      c++;
    end
    #2;
    tests++;
    if (in_q.size() != n0 + 1 || in_q[n0] != 1 || in_outs[n0] != 2) begin
      fails++;
      $display("FAIL bp_ch1: transfers %0d (required %0d), ch1 taken after %0d report words (required 2)",
               in_q.size(), n0 + 1, (in_outs.size() > n0) ? in_outs[n0] : -1);
    end else
      $display("[TB] bp_ch1 accepted after report ok");
    tests++;
    if (dut.sum[1] !== 16'h0077) begin
      fails++;
      $display("FAIL bp_ch1_sum: got %h, required 0077", dut.sum[1]);
    end
  endtask

  task automatic test_discard();
    int n = 0;
    int c = 0;
    int seen = 0;
    apply_reset();
    d_data = 64'h0003_0000_0000_0000;
    d_stb  = 4'b1000;
    while (n < 6 && c < 100) begin
      @(posedge clk);
      #2;
      c++;
      if (d_out_stb) seen++;
      if (d_ack[3] && d_stb[3]) n++;
    end
    @(posedge clk);
    #1 d_stb = 4'b0000;
    repeat (10) begin
      @(posedge clk);
      #2;
      if (d_out_stb) seen++;
    end
    tests++;
    if (n != 6) begin
      fails++;
      $display("FAIL discard_xfers: got %0d, required 6", n);
    end else
      $display("[TB] discard 6 transfers ok");
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL discard_stb: stb high %0d cycles, required 0", seen);
    end
    tests++;
    if (dut_d.sum[3] !== 16'h0000 || dut_d.count[3] !== 16'd0) begin
      fails++;
      $display("FAIL discard_clear: sum %h count %0d, required 0000 0", dut_d.sum[3], dut_d.count[3]);
    end
  endtask

  task automatic test_reset_mid();
    int c = 0;
    apply_reset();
    out_ack = 1'b1;
    for (int i = 0; i < 4; i++) chan_q[1].push_back(16'h0020);
    while (in_q.size() < 2 && c < 100) begin
      @(posedge clk);
      c++;
    end
    #2;
    apply_reset();
    for (int i = 0; i < 4; i++) chan_q[1].push_back(16'h0010);
    wait_outputs(2, 100, "rmid");
    check_out(0, 16'h0001, "rmid");
    check_out(1, 16'h0040, "rmid");
    repeat (20) @(posedge clk);
    #2;
    tests++;
    if (out_q.size() != 2) begin
      fails++;
      $display("FAIL rmid_count: got %0d report words, required 2", out_q.size());
    end
  endtask

  task automatic test_onehot();
    tests++;
    if (onehot_err != 0) begin
      fails++;
      $display("FAIL ack_onehot: %0d violating cycles, required 0", onehot_err);
    end
  endtask

  initial begin
    rst = 1'b0;
    in_data = '0;
    in_stb = '0;
    out_ack = 1'b0;
    d_data = '0;
    d_stb = '0;
    d_out_ack = 1'b1;
    test_reset();
    test_basic();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_discard();
    test_reset_mid();
    test_onehot();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
